// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: operand forwarding, ALU control, ALU,
// branch-target adder and destination select, captured with stall/flush support.
module ex_mem_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       WB,
    input  logic [2:0]       M,
    input  logic             RegDst,
    input  logic [1:0]       ALUop,
    input  logic             ALUsrc,
    input  logic [WIDTH-1:0] NextAdress,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [WIDTH-1:0] SignExt,
    input  logic [REGW-1:0]  RT,
    input  logic [REGW-1:0]  RD,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] MemFwd,
    input  logic [WIDTH-1:0] WbFwd,
    input  logic             Stall,
    input  logic             Flush,
    output logic [1:0]       O_WB,
    output logic [2:0]       O_M,
    output logic [WIDTH-1:0] O_BranchTarget,
    output logic             O_Zero,
    output logic [WIDTH-1:0] O_ALUResult,
    output logic [WIDTH-1:0] O_StoreData,
    output logic [REGW-1:0]  O_WriteReg
);

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluNor,
        AluSlt
    } alu_op_e;

    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_target;
    logic [REGW-1:0]  w_write_reg;
    logic             w_slt;
    alu_op_e          w_alu_op;

    // Select 11 is unused and falls back to the register operand.
    always_comb begin
        unique case (ForwardA)
            2'b10:   w_fwd_a = MemFwd;
            2'b01:   w_fwd_a = WbFwd;
            default: w_fwd_a = OP1;
        endcase
        unique case (ForwardB)
            2'b10:   w_fwd_b = MemFwd;
            2'b01:   w_fwd_b = WbFwd;
            default: w_fwd_b = OP2;
        endcase
    end

    assign w_alu_b = ALUsrc ? SignExt : w_fwd_b;

    always_comb begin
        w_alu_op = AluAdd;
        unique case (ALUop)
            2'b00: w_alu_op = AluAdd;
            2'b01: w_alu_op = AluSub;
            2'b11: w_alu_op = AluSlt;
            default: begin
                unique case (SignExt[5:0])
                    6'h22:   w_alu_op = AluSub;
                    6'h24:   w_alu_op = AluAnd;
                    6'h25:   w_alu_op = AluOr;
                    6'h27:   w_alu_op = AluNor;
                    6'h2A:   w_alu_op = AluSlt;
                    default: w_alu_op = AluAdd;
                endcase
            end
        endcase
    end

    assign w_slt = ($signed(w_fwd_a) < $signed(w_alu_b));

    always_comb begin
        w_result = '0;
        unique case (w_alu_op)
            AluSub:  w_result = w_fwd_a - w_alu_b;
            AluAnd:  w_result = w_fwd_a & w_alu_b;
            AluOr:   w_result = w_fwd_a | w_alu_b;
            AluNor:  w_result = ~(w_fwd_a | w_alu_b);
            AluSlt:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_result = w_fwd_a + w_alu_b;
        endcase
    end

    assign w_target    = NextAdress + {SignExt[WIDTH-3:0], 2'b00};
    assign w_write_reg = RegDst ? RD : RT;

    // Flush outranks stall so a squashed instruction never lingers in the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_WB           <= '0;
            O_M            <= '0;
            O_BranchTarget <= '0;
            O_Zero         <= 1'b0;
            O_ALUResult    <= '0;
            O_StoreData    <= '0;
            O_WriteReg     <= '0;
        end else if (Flush) begin
            O_WB           <= '0;
            O_M            <= '0;
            O_BranchTarget <= '0;
            O_Zero         <= 1'b0;
            O_ALUResult    <= '0;
            O_StoreData    <= '0;
            O_WriteReg     <= '0;
        end else if (!Stall) begin
            O_WB           <= WB;
            O_M            <= M;
            O_BranchTarget <= w_target;
            O_Zero         <= (w_result == '0);
            O_ALUResult    <= w_result;
            O_StoreData    <= w_fwd_b;
            O_WriteReg     <= w_write_reg;
        end
    end

endmodule
